ch_pack_fifo: RTL and testbench
===============================

// Module: ch_pack_fifo
// PURPOSE
//  - Single-clock, parametrised successor to the per-channel capture FIFO.
//  - Packs RATIO narrow ADC samples into one wide word and buffers DEPTH words for the host stream.
//  - Sits between the ADC deserialiser output and the host read interface.
//  - Adds over the previous channel FIFO: fill count, sticky overflow/underflow, optional partial-word flush.
// PARAMETERS
//  IN_W   8     sample width, bits
//  RATIO  4     samples per output word; OUT_W = IN_W*RATIO (localparam)
//  DEPTH  1024  FIFO depth in output words; power of two, >= 4
// PORTS
//  clk     in   1              single clock for write and read
//  rst     in   1              synchronous, active-high reset
//  din     in   IN_W           ADC sample
//  wr_en   in   1              sample strobe
//  rd_en   in   1              pop request
//  dout    out  OUT_W          read data, registered
//  full    out  1              count == DEPTH
//  empty   out  1              count == 0
//  count   out  log2(DEPTH)+1  stored words
//  ovf     out  1              sticky: sample or word dropped
//  udf     out  1              sticky: rd_en while empty
//  flush   in   1              only with CHF_FLUSH_EN: push partial word
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge) dominates all other inputs:
//    - lane=0, pointers=0, count=0, dout=0, ovf=0, udf=0, empty=1, full=0.
//    - Memory contents are not cleared. A reset mid-word discards the partial word.
//  - Packing order: first sample of a word lands in the MSBs, dout[OUT_W-1 -: IN_W]; the last lands in [IN_W-1:0].
//  - Lane counter 0..RATIO-1:
//    - wr_en & !full: din is stored in the current lane and lane increments.
//    - At lane RATIO-1 the completed word is pushed and lane wraps to 0.
//  - wr_en & full:
//    - The sample is dropped, lane is unchanged, and ovf is set.
//    - The write is still dropped if rd_en is asserted in the same cycle; full is evaluated before the pop.
//  - Pop: rd_en & !empty.
//    - dout takes mem[rptr] on that edge, so data is valid the cycle after the rd_en cycle.
//    - dout holds its value when there is no pop.
//  - rd_en & empty: ignored, dout holds, udf is set.
//  - Push and pop in the same cycle: count is unchanged, both pointers advance. Legal at count 1..DEPTH-1.
//  - count, full and empty are registered and update on the edge after the push or pop.
//    - Word completed at edge N: empty deasserts and count increments after edge N.
//    - Pop at edge N: count decrements after edge N.
//  - Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
//  - ovf and udf are cleared only by rst.
//  - No read-first/write-first hazard: a word is never popped in the cycle it is pushed, because empty is registered.
// CONFIGURATION
//  - CHF_FLUSH_EN defined: flush port present.
//    - flush & lane>0: the partial word is pushed with unfilled lanes zero, and lane is set to 0.
//    - If wr_en is also asserted, din fills the current lane first, then the word is pushed.
//    - flush & lane==0 & !wr_en: no action.
//    - flush while full: the word is dropped, ovf is set, lane is set to 0.
//  - CHF_FLUSH_EN undefined:
//    - No flush port.
//    - Partial samples stay in the packer until RATIO samples arrive.
// TESTING
//  - Reset, then 8 wr_en with din=01..08.
//    - Required: count=2.
//    - Two pops give dout=01020304 then 05060708; empty=1 afterwards.
//  - Fill DEPTH words (4*DEPTH samples), then one more wr_en.
//    - Required: full=1, count=DEPTH, ovf=1.
//    - Draining all words returns the original sequence intact.
//  - rd_en with FIFO empty after reset.
//    - Required: udf=1, dout=0, count=0.
//  - Continuous write at count=DEPTH/2 with rd_en every 4th cycle.
//    - Required: count constant over 4 cycles; no ovf or udf; data in order across pointer wrap.
//  - Write 2 samples AA, BB, then rst=1 for one cycle, then 4 samples 11..14.
//    - Required: the single pop gives 11121314.
//  - CHF_FLUSH_EN: samples AA, BB, then flush.
//    - Required: count=1, dout=AABB0000, lane=0.
//    - Flush with lane=0 and no wr_en: count unchanged.

Source files
------------

// File: rtl/ch_pack_fifo.sv
// Packs RATIO narrow ADC samples into one wide word and queues DEPTH words for the host.
// Optional partial-word flush port is enabled by defining CHF_FLUSH_EN.
module ch_pack_fifo #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_W-1:0]           din,
    input  logic                      wr_en,
    input  logic                      rd_en,
`ifdef CHF_FLUSH_EN
    input  logic                      flush,
`endif
    output logic [IN_W*RATIO-1:0]     dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf,
    output logic                      udf
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [OUT_W-1:0] mem [DEPTH];

    logic [LW-1:0]    lane_q,  lane_d;
    logic [OUT_W-1:0] pack_q,  pack_d;
    logic [AW-1:0]    wptr_q,  wptr_d;
    logic [AW-1:0]    rptr_q,  rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;
    logic [OUT_W-1:0] dout_q,  dout_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             flush_s;
    logic             wr_ok_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [OUT_W-1:0] word_s;

`ifdef CHF_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Packer, pointer, occupancy and sticky-flag next-state logic
    always_comb begin
        wr_ok_s = wr_en & ~full_q;
        word_s  = pack_q;
        if (wr_ok_s) begin
            word_s[(OUT_W - 1) - int'(lane_q) * IN_W -: IN_W] = din;
        end else begin
            word_s = pack_q;
        end

        // Flush with a sample in the same cycle pushes the word including that sample
        push_s = (wr_ok_s & (lane_q == LAST_LANE))
               | (flush_s & ~full_q & ((lane_q != {LW{1'b0}}) | wr_en));
        drop_s = flush_s & full_q;
        pop_s  = rd_en & ~empty_q;

        if (push_s || drop_s) begin
            lane_d = {LW{1'b0}};
            pack_d = {OUT_W{1'b0}};
        end else if (wr_ok_s) begin
            lane_d = lane_q + LW'(1);
            pack_d = word_s;
        end else begin
            lane_d = lane_q;
            pack_d = pack_q;
        end

        wptr_d = push_s ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d = pop_s  ? (rptr_q + AW'(1)) : rptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == {(AW + 1){1'b0}});
        dout_d  = pop_s ? mem[rptr_q] : dout_q;
        ovf_d   = ovf_q | (wr_en & full_q) | (drop_s & (lane_q != {LW{1'b0}}));
        udf_d   = udf_q | (rd_en & empty_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= {LW{1'b0}};
            pack_q  <= {OUT_W{1'b0}};
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {(AW + 1){1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dout_q  <= {OUT_W{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Word storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem[wptr_q] <= word_s;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_ch_pack_fifo.sv
// Scoreboard bench for ch_pack_fifo: queue-based reference model, decoupled dout monitor.
module tb_ch_pack_fifo;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int DEPTH = 1024;
    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  din = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             flush = 1'b0;
    logic [OUT_W-1:0] dout;
    logic             full, empty, ovf, udf;
    logic [AW:0]      count;

    int checks = 0;
    int errors = 0;

    bit [IN_W-1:0]  part_q [$];
    bit [OUT_W-1:0] fifo_q [$];
    bit [OUT_W-1:0] exp_q  [$];
    bit             m_ovf = 1'b0;
    bit             m_udf = 1'b0;
    bit [OUT_W-1:0] hold = '0;
    bit             do_pop;

    ch_pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .wr_en (wr_en),
        .rd_en (rd_en),
`ifdef CHF_FLUSH_EN
        .flush (flush),
`endif
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic bit [OUT_W-1:0] pack_word();
        bit [OUT_W-1:0] w = '0;
        for (int i = 0; i < part_q.size(); i++) w[OUT_W-1-IN_W*i -: IN_W] = part_q[i];
        return w;
    endfunction

    // Reference behaviour for one clock edge, expressed on sample/word queues
    task automatic model_edge(input bit w, input bit [IN_W-1:0] d, input bit r, input bit f, input bit rs);
        bit mfull, memp;
        if (rs) begin
            part_q.delete(); fifo_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
            return;
        end
        mfull = (fifo_q.size() == DEPTH);
        memp  = (fifo_q.size() == 0);
        if (r) begin
            if (!memp) exp_q.push_back(fifo_q.pop_front());
            else m_udf = 1'b1;
        end
        if (w) begin
            if (mfull) m_ovf = 1'b1;
            else begin
                part_q.push_back(d);
                if (part_q.size() == RATIO) begin
                    fifo_q.push_back(pack_word());
                    part_q.delete();
                end
            end
        end
        if (f) begin
            if (mfull) begin
                if (part_q.size() > 0 || w) m_ovf = 1'b1;
                part_q.delete();
            end else if (part_q.size() > 0) begin
                fifo_q.push_back(pack_word());
                part_q.delete();
            end
        end
    endtask

    task automatic step(input bit w, input bit [IN_W-1:0] d, input bit r, input bit f, input bit rs);
        wr_en = w; din = d; rd_en = r; flush = f; rst = rs;
        @(posedge clk);
        model_edge(w, d, r, f, rs);
        @(negedge clk);
        chk("count", 64'(count), 64'(fifo_q.size()));
        chk("empty", 64'(empty), 64'(fifo_q.size() == 0));
        chk("full",  64'(full),  64'(fifo_q.size() == DEPTH));
        chk("ovf",   64'(ovf),   64'(m_ovf));
        chk("udf",   64'(udf),   64'(m_udf));
    endtask

    // Monitor: a DUT pop at an edge must present the next scoreboard word; otherwise dout holds
    initial begin
        forever begin
            @(posedge clk);
            do_pop = !rst && rd_en && !empty;
            if (rst) hold = '0;
            @(negedge clk);
            if (do_pop) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL pop_unexpected actual=%0h expected=none", dout);
                end else begin
                    hold = exp_q.pop_front();
                end
            end
            chk("dout", 64'(dout), 64'(hold));
        end
    end

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);

        // Underflow after reset
        step(0, 0, 1, 0, 0);
        chk("udf_flag", 64'(udf), 64'h1);
        chk("udf_dout", 64'(dout), 64'h0);
        chk("udf_count", 64'(count), 64'h0);

        // Basic packing order
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(1, IN_W'(i), 0, 0, 0);
        chk("pack_count", 64'(count), 64'h2);
        step(0, 0, 1, 0, 0);
        chk("pop1", 64'(dout), 64'h01020304);
        step(0, 0, 1, 0, 0);
        chk("pop2", 64'(dout), 64'h05060708);
        chk("pop_empty", 64'(empty), 64'h1);

        // Fill to DEPTH, overflow one sample, drain
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4 * DEPTH; i++) step(1, IN_W'($urandom), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("fill_full", 64'(full), 64'h1);
        chk("fill_count", 64'(count), 64'(DEPTH));
        chk("fill_ovf", 64'(ovf), 64'h1);
        step(1, 8'hEF, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
        chk("drain_empty", 64'(empty), 64'h1);

        // Steady state at half full across pointer wrap
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 2 * DEPTH; i++) step(1, IN_W'($urandom), 0, 0, 0);
        for (int c = 0; c < 4 * DEPTH + 8; c++) begin
            step(1, IN_W'($urandom), (c % 4) == 3, 0, 0);
            if ((c % 4) == 3) chk("steady_count", 64'(count), 64'(DEPTH / 2));
        end
        chk("steady_ovf", 64'(ovf), 64'h0);
        chk("steady_udf", 64'(udf), 64'h0);

        // Reset discards a partial word
        step(0, 0, 0, 0, 1);
        step(1, 8'hAA, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, IN_W'(8'h11 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("rst_mid_word", 64'(dout), 64'h11121314);

`ifdef CHF_FLUSH_EN
        step(0, 0, 0, 0, 1);
        step(1, 8'hAA, 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("flush_count", 64'(count), 64'h1);
        step(0, 0, 0, 1, 0);
        chk("flush_idle_count", 64'(count), 64'h1);
        step(0, 0, 1, 0, 0);
        chk("flush_dout", 64'(dout), 64'hAABB0000);
        for (int i = 0; i < 4; i++) step(1, IN_W'(8'h21 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("flush_lane0", 64'(dout), 64'h21222324);
`endif

        // Randomized traffic
        step(0, 0, 0, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            bit f = 1'b0;
`ifdef CHF_FLUSH_EN
            f = ($urandom_range(0, 19) == 0);
`endif
            step($urandom_range(0, 9) < 7, IN_W'($urandom), $urandom_range(0, 9) < 3, f,
                 $urandom_range(0, 999) == 0);
        end
        step(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
